lcd_reg_view: RTL and testbench

LCD_REG_VIEW -- requirements
Module: lcd_reg_view

---
 rtl/lcd_reg_view_pkg.sv | 16 +
 rtl/lcd_byte_writer.sv | 48 ++++
 rtl/lcd_reg_view.sv | 99 +++++++++
 tb/tb_lcd_reg_view.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_reg_view_pkg.sv
// lcd_reg_view_pkg: FSM state enum, HD44780 command bytes and the nibble-to-ASCII helper shared by the display block
package lcd_reg_view_pkg;
  typedef enum logic [2:0] {
    PWR_WAIT, INIT, SNAP, LINE1_CMD, LINE1_CHR, LINE2_CMD, LINE2_CHR, DONE
  } state_t;
  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_MODE  = 8'h06;
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CHR_SPC   = 8'h20;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one HD44780 byte write (setup clock, en pulse, settle); in: start, wr_byte, rs, is_clear; out: lcd_data, lcd_rs, lcd_en, done (pulse in last settle clock)
module lcd_byte_writer #(
  parameter int T_EN_CYC  = 25,
  parameter int T_CMD_CYC = 2_500,
  parameter int T_CLR_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] wr_byte,
  input  logic       rs,
  input  logic       is_clear,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done
);
  localparam int T_SET_MAX = T_CLR_CYC > T_CMD_CYC ? T_CLR_CYC : T_CMD_CYC;
  localparam int KW = $clog2(T_EN_CYC + T_SET_MAX + 2);
  localparam logic [KW-1:0] K_EN  = KW'(T_EN_CYC);
  localparam logic [KW-1:0] K_CMD = KW'(T_EN_CYC + T_CMD_CYC);
  localparam logic [KW-1:0] K_CLR = KW'(T_EN_CYC + T_CLR_CYC);
  logic          busy, clr;
  logic [KW-1:0] k;
  // k counts clocks within the byte: 0 = setup, 1..T_EN = strobe, then settle
  assign done = busy && k == (clr ? K_CLR : K_CMD);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      clr      <= 1'b0;
      k        <= '0;
      lcd_en   <= 1'b0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      clr      <= is_clear;
      k        <= '0;
      lcd_en   <= 1'b0;
      lcd_data <= wr_byte;
      lcd_rs   <= rs;
    end else if (busy) begin
      busy   <= !done;
      k      <= done ? '0 : k + 1'b1;
      lcd_en <= k < K_EN;
    end
  end
endmodule

// File: rtl/lcd_reg_view.sv
// lcd_reg_view: HD44780 8-bit viewer of x0..x7 as hex on two lines; in: clk, rst, x0..x7; out: lcd_data, lcd_rs, lcd_rw, lcd_en, frame_done
module lcd_reg_view
  import lcd_reg_view_pkg::*;
#(
  parameter int T_PWR_CYC = 1_000_000,
  parameter int T_EN_CYC  = 25,
  parameter int T_CMD_CYC = 2_500,
  parameter int T_CLR_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] x3,
  input  logic [7:0] x4,
  input  logic [7:0] x5,
  input  logic [7:0] x6,
  input  logic [7:0] x7,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       frame_done
);
  localparam int PW = $clog2(T_PWR_CYC + 1);
  state_t         state, state_n;
  logic [PW-1:0]  tmr;
  logic [4:0]     idx, n_bytes;
  logic [7:0][7:0] snap;
  logic [7:0]     xr, chr, init_b, wr_byte;
  logic [3:0]     p;
  logic [2:0]     sel;
  logic           send, start, leave, wr_rs, wr_done, is_clear, en_q;
  assign lcd_rw     = 1'b0;
  assign frame_done = state == DONE;
  // A state leaves as soon as its last byte's strobe falls, so DONE/SNAP run
  // inside that byte's settle window; the next state starts on the writer's
  // done pulse, keeping byte spacing exact. This needs T_CMD_CYC >= 4.
  always_comb begin
    p        = idx[3:0];
    sel      = {state == LINE2_CHR, 2'(p / 4'd3)};
    xr       = snap[sel];
    chr      = (p > 4'd10 || p % 4'd3 == 4'd2) ? CHR_SPC
             : hex_ascii(p % 4'd3 == 4'd0 ? xr[7:4] : xr[3:0]);
    init_b   = idx[1:0] == 2'd0 ? CMD_FUNC : idx[1:0] == 2'd1 ? CMD_DISP
             : idx[1:0] == 2'd2 ? CMD_MODE : CMD_CLR;
    wr_byte  = state == INIT ? init_b : state == LINE1_CMD ? CMD_LINE1
             : state == LINE2_CMD ? CMD_LINE2 : chr;
    wr_rs    = state == LINE1_CHR || state == LINE2_CHR;
    is_clear = state == INIT && init_b == CMD_CLR;
    n_bytes  = state == INIT ? 5'd4 : wr_rs ? 5'd16 : 5'd1;
    send     = state inside {INIT, LINE1_CMD, LINE1_CHR, LINE2_CMD, LINE2_CHR};
    start    = send && idx < n_bytes && (wr_done || (state == INIT && idx == 5'd0));
    leave    = send && idx == n_bytes && en_q && !lcd_en;
    state_n  = state;
    case (state)
      PWR_WAIT:  state_n = tmr == PW'(T_PWR_CYC - 1) ? INIT : PWR_WAIT;
      INIT:      state_n = leave ? SNAP : INIT;
      SNAP:      state_n = LINE1_CMD;
      LINE1_CMD: state_n = leave ? LINE1_CHR : LINE1_CMD;
      LINE1_CHR: state_n = leave ? LINE2_CMD : LINE1_CHR;
      LINE2_CMD: state_n = leave ? LINE2_CHR : LINE2_CMD;
      LINE2_CHR: state_n = leave ? DONE : LINE2_CHR;
      default:   state_n = SNAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWR_WAIT;
      tmr   <= '0;
      idx   <= '0;
      snap  <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= state == PWR_WAIT ? tmr + 1'b1 : '0;
      idx   <= state_n != state ? '0 : idx + {4'd0, start};
      en_q  <= lcd_en;
      if (state == SNAP) snap <= {x7, x6, x5, x4, x3, x2, x1, x0};
    end
  end
  lcd_byte_writer #(
    .T_EN_CYC (T_EN_CYC),
    .T_CMD_CYC(T_CMD_CYC),
    .T_CLR_CYC(T_CLR_CYC)
  ) u_wr (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr_byte (wr_byte),
    .rs      (wr_rs),
    .is_clear(is_clear),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_en  (lcd_en),
    .done    (wr_done)
  );
endmodule

// File: tb/tb_lcd_reg_view.sv
// tb_lcd_reg_view: randomized self-checking bench comparing the LCD byte stream against a formatted-string model
module tb_lcd_reg_view;
  localparam int T_PWR = 10, T_EN = 2, T_CMD = 4, T_CLR = 8;
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } wr_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] x [8];
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, frame_done;
  int         checks = 0, errors = 0;
  wr_t        q [$];
  int         cyc = 0, fall_cyc = -1, width = 0, fd_count = 0;
  logic       en_q = 1'b0, fd_q = 1'b0, rst_hit = 1'b0;
  logic [8:0] held;

  always #5 clk = ~clk;

  lcd_reg_view #(
    .T_PWR_CYC(T_PWR), .T_EN_CYC(T_EN), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)
  ) dut (
    .clk(clk), .rst(rst),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .frame_done(frame_done)
  );

  // Bus monitor: records each byte at its strobe, with the clock distance from
  // the previous strobe's fall (settle plus the one setup clock).
  always @(negedge clk) begin
    cyc++;
    if (frame_done) begin
      fd_count++;
      checks++;
      if (fd_q) begin
        errors++;
        $display("FAIL frame_done_width: high for more than 1 clock at cycle %0d, required 1", cyc);
      end
    end
    if (lcd_en && !en_q) begin
      q.push_back('{lcd_rs, lcd_data, fall_cyc < 0 ? -1 : cyc - fall_cyc});
      held    = {lcd_rs, lcd_data};
      width   = 1;
      rst_hit = rst;
    end else if (lcd_en) begin
      width++;
      rst_hit |= rst;
      checks++;
      if ({lcd_rs, lcd_data} !== held) begin
        errors++;
        $display("FAIL en_stable: rs/data %h while en high, required %h", {lcd_rs, lcd_data}, held);
      end
    end else if (en_q) begin
      fall_cyc = cyc;
      if (!rst_hit) begin
        checks++;
        if (width != T_EN) begin
          errors++;
          $display("FAIL en_width: pulse %0d clocks, required %0d", width, T_EN);
        end
      end
      checks++;
      if (lcd_rw !== 1'b0) begin
        errors++;
        $display("FAIL rw: lcd_rw %b, required 0", lcd_rw);
      end
    end
    en_q = lcd_en;
    fd_q = frame_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n, input string tag);
    int t = 0;
    while (q.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes seen, required %0d", tag, q.size(), n);
    end
  endtask

  // Called just after an edge that sampled rst=1 with rst still high.
  task automatic test_release(input string tag);
    int n = 0;
    rst = 1'b0;
    q.delete();
    fall_cyc = -1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      if (lcd_en) break;
      n++;
    end
    checks++;
    if (n != T_PWR + 1) begin
      errors++;
      $display("FAIL %s_first_en: en rose %0d clocks after release, required %0d", tag, n, T_PWR + 1);
    end
    checks++;
    if ({lcd_rs, lcd_data} !== {1'b0, 8'h38}) begin
      errors++;
      $display("FAIL %s_first_byte: rs/data %h, required 038", tag, {lcd_rs, lcd_data});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_en, frame_done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: data/rs/rw/en/fd %h, required 000", {lcd_data, lcd_rs, lcd_rw, lcd_en, frame_done});
    end
    test_release("reset");
  endtask

  task automatic test_init(input string tag);
    logic [7:0] exp_b [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    wait_q(5, tag);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({q[i].rs, q[i].d} !== {1'b0, exp_b[i]}) begin
        errors++;
        $display("FAIL %s_byte%0d: rs/data %h, required %h", tag, i, {q[i].rs, q[i].d}, {1'b0, exp_b[i]});
      end
      if (i > 0) begin
        checks++;
        if (q[i].gap != T_CMD + 1) begin
          errors++;
          $display("FAIL %s_gap%0d: %0d clocks, required %0d", tag, i, q[i].gap, T_CMD + 1);
        end
      end
    end
    checks++;
    if (q[4].gap != T_CLR + 1 || {q[4].rs, q[4].d} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL %s_after_clear: byte %h gap %0d, required 080 gap %0d", tag, {q[4].rs, q[4].d}, q[4].gap, T_CLR + 1);
    end
    repeat (4) void'(q.pop_front());
  endtask

  // Checks one frame against cur; drives nxt once line 1 is under way.
  task automatic test_frame(input logic [7:0] cur [8], input logic [7:0] nxt [8], input int first_gap, input string tag);
    string s1, s2;
    logic [8:0] exp_w [34];
    int fd0 = fd_count;
    int t = 0;
    s1 = $sformatf("%02x %02x %02x %02x     ", cur[0], cur[1], cur[2], cur[3]);
    s2 = $sformatf("%02x %02x %02x %02x     ", cur[4], cur[5], cur[6], cur[7]);
    s1 = s1.toupper();
    s2 = s2.toupper();
    exp_w[0]  = {1'b0, 8'h80};
    exp_w[17] = {1'b0, 8'hC0};
    for (int i = 0; i < 16; i++) begin
      exp_w[1 + i]  = {1'b1, s1[i]};
      exp_w[18 + i] = {1'b1, s2[i]};
    end
    wait_q(2, tag);
    x = nxt;
    wait_q(34, tag);
    for (int i = 0; i < 34 && i < q.size(); i++) begin
      checks++;
      if ({q[i].rs, q[i].d} !== exp_w[i] || q[i].gap != (i == 0 ? first_gap : T_CMD + 1)) begin
        errors++;
        $display("FAIL %s_byte%0d: rs/data %h gap %0d, required %h gap %0d", tag, i,
                 {q[i].rs, q[i].d}, q[i].gap, exp_w[i], i == 0 ? first_gap : T_CMD + 1);
      end
    end
    while (q.size() > 0 && t < 34) begin
      void'(q.pop_front());
      t++;
    end
    t = 0;
    while (fd_count == fd0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (fd_count != fd0 + 1) begin
      errors++;
      $display("FAIL %s_frame_done: %0d pulses, required 1", tag, fd_count - fd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] cur [8];
    int t = 0;
    cur = x;
    while (!(q.size() == 18 && lcd_en && lcd_rs) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL mid_reset_wait: no line-2 strobe within %0d clocks, required one", t);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({lcd_data, lcd_rs, lcd_en, frame_done} !== 11'h000) begin
      errors++;
      $display("FAIL mid_reset_outputs: data/rs/en/fd %h, required 000", {lcd_data, lcd_rs, lcd_en, frame_done});
    end
    test_release("mid_reset");
    test_init("reinit");
    test_frame(cur, cur, T_CLR + 1, "after_reset");
  endtask

  initial begin
    logic [7:0] a [8], b [8];
    x = '{8'h3C, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hA5, 8'hA5};
    test_reset();
    test_init("init");
    a = x;
    foreach (b[i]) b[i] = 8'($urandom);
    b[0] = 8'h12;
    test_frame(a, b, T_CLR + 1, "pattern");
    a = b;
    foreach (b[i]) b[i] = 8'($urandom);
    b[0] = 8'h34;
    test_frame(a, b, T_CMD + 1, "snap_12");
    for (int f = 0; f < 3; f++) begin
      a = b;
      foreach (b[i]) b[i] = 8'($urandom);
      test_frame(a, b, T_CMD + 1, $sformatf("rand%0d", f));
    end
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
